// File: rtl/press_counter_uart_report.sv
// Counts debounced button presses in BCD and reports each count over a byte-wide
// valid/ready link as ASCII decimal digits (MSD first) with optional CR/LF.
module press_counter_uart_report #(
  parameter int NUM_DIGITS = 3,
  parameter int SEND_CRLF  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    PB_down,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] count_bcd
);

  localparam int CW    = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DIGIT, CR, LF} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d, count_inc;
  logic [CW-1:0]    snap_q, snap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [3:0]       digit_d;
  logic             carry;
  logic             msg_done;

  always_comb begin
    count_inc = count_q;
    carry     = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    pending_d = pending_q;
    msg_done  = 1'b0;
    count_d   = PB_down ? count_inc : count_q;

    case (state_q)
      IDLE: begin
        if (PB_down) state_d = LOAD;
      end
      LOAD: begin
        snap_d    = count_q;
        idx_d     = IDX_TOP;
        pending_d = 1'b0;
        state_d   = DIGIT;
      end
      DIGIT: begin
        if (PB_down) pending_d = 1'b1;
        if (tx_ready) begin
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else if (SEND_CRLF != 0) begin
            state_d = CR;
          end else begin
            msg_done = 1'b1;
          end
        end
      end
      CR: begin
        if (PB_down) pending_d = 1'b1;
        if (tx_ready) state_d = LF;
      end
      LF: begin
        if (PB_down) pending_d = 1'b1;
        if (tx_ready) msg_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A press on the final accept edge restarts immediately, same as a pending one.
    if (msg_done) state_d = (pending_q || PB_down) ? LOAD : IDLE;
  end

  always_comb begin
    digit_d = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) digit_d = snap_d[4*i +: 4];
    end
  end

  // Outputs are registered from next-state values so they never depend on tx_ready combinationally.
  always_comb begin
    tx_valid_d = 1'b0;
    tx_data_d  = '0;
    busy_d     = (state_d != IDLE);
    case (state_d)
      DIGIT: begin
        tx_valid_d = 1'b1;
        tx_data_d  = 8'h30 + {4'h0, digit_d};
      end
      CR: begin
        tx_valid_d = 1'b1;
        tx_data_d  = 8'h0D;
      end
      LF: begin
        tx_valid_d = 1'b1;
        tx_data_d  = 8'h0A;
      end
      default: begin
        tx_valid_d = 1'b0;
        tx_data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      snap_q     <= '0;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign count_bcd = count_q;

endmodule

// File: tb/tb_press_counter_uart_report.sv
// Directed bench for press_counter_uart_report: a 3-digit CR/LF instance and a
// 1-digit bare-digit instance, bytes captured on each valid/ready transfer.
module tb_press_counter_uart_report;

  logic        clk = 1'b0;
  logic        rst;
  logic        pb_a, rdy_a, valid_a, busy_a;
  logic [7:0]  data_a;
  logic [11:0] count_a;
  logic        pb_b, rdy_b, valid_b, busy_b;
  logic [7:0]  data_b;
  logic [3:0]  count_b;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int n_checks = 0;
  int n_fail   = 0;

  press_counter_uart_report #(.NUM_DIGITS(3), .SEND_CRLF(1)) dut_a (
    .clk(clk), .rst(rst), .PB_down(pb_a), .tx_ready(rdy_a),
    .tx_valid(valid_a), .tx_data(data_a), .busy(busy_a), .count_bcd(count_a)
  );

  press_counter_uart_report #(.NUM_DIGITS(1), .SEND_CRLF(0)) dut_b (
    .clk(clk), .rst(rst), .PB_down(pb_b), .tx_ready(rdy_b),
    .tx_valid(valid_b), .tx_data(data_b), .busy(busy_b), .count_bcd(count_b)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after posedge, so at negedge they show what the next edge will transfer.
  always @(negedge clk) begin
    if (!rst && valid_a && rdy_a) qa.push_back(data_a);
    if (!rst && valid_b && rdy_b) qb.push_back(data_b);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_a();
    pb_a = 1'b1;
    cyc(1);
    pb_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget, output int vcnt);
    vcnt = 0;
    for (int i = 0; i < budget; i++) begin
      if (!busy_a) break;
      if (valid_a) vcnt++;
      cyc(1);
    end
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout_a: busy=%b required 0 within %0d cycles", busy_a, budget);
    end
  endtask

  task automatic wait_idle_b(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy_b) break;
      cyc(1);
    end
    n_checks++;
    if (busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout_b: busy=%b required 0 within %0d cycles", busy_b, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    n_checks++;
    if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", valid_a); end
    n_checks++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy_a); end
    n_checks++;
    if (count_a !== 12'h000) begin n_fail++; $display("FAIL reset_count: got %h required 000", count_a); end
    n_checks++;
    if (data_a !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h required 00", data_a); end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_single();
    logic [7:0] e [5] = '{8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};
    logic [7:0] got;
    int v;
    qa.delete();
    rdy_a = 1'b1;
    press_a();
    n_checks++;
    if (count_a !== 12'h001) begin n_fail++; $display("FAIL single_count: got %h required 001", count_a); end
    n_checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL single_load: valid=%b busy=%b required 0 1", valid_a, busy_a);
    end
    cyc(1);
    n_checks++;
    if (valid_a !== 1'b1 || data_a !== 8'h30) begin
      n_fail++; $display("FAIL single_first: valid=%b data=%h required 1 30", valid_a, data_a);
    end
    wait_idle_a(50, v);
    n_checks++;
    if (v !== 5) begin n_fail++; $display("FAIL single_valid_cycles: got %0d required 5", v); end
    n_checks++;
    if (qa.size() !== 5) begin n_fail++; $display("FAIL single_len: got %0d required 5", qa.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      n_checks++;
      if (got !== e[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h required %h", i, got, e[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e [5] = '{8'h30, 8'h30, 8'h32, 8'h0D, 8'h0A};
    logic [7:0] got;
    int v;
    qa.delete();
    press_a();
    cyc(2);
    rdy_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      n_checks++;
      if (valid_a !== 1'b1 || data_a !== 8'h30) begin
        n_fail++; $display("FAIL stall_hold%0d: valid=%b data=%h required 1 30", i, valid_a, data_a);
      end
    end
    rdy_a = 1'b1;
    wait_idle_a(50, v);
    n_checks++;
    if (qa.size() !== 5) begin n_fail++; $display("FAIL stall_len: got %0d required 5", qa.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      n_checks++;
      if (got !== e[i]) begin n_fail++; $display("FAIL stall_byte%0d: got %h required %h", i, got, e[i]); end
    end
  endtask

  task automatic test_pending();
    logic [7:0] e [10] = '{8'h30, 8'h30, 8'h34, 8'h0D, 8'h0A, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A};
    logic [7:0] got;
    int v;
    press_a();
    wait_idle_a(50, v);
    qa.delete();
    press_a();
    cyc(1);
    rdy_a = 1'b0;
    press_a();
    cyc(1);
    press_a();
    cyc(1);
    press_a();
    n_checks++;
    if (count_a !== 12'h007) begin n_fail++; $display("FAIL pend_count: got %h required 007", count_a); end
    rdy_a = 1'b1;
    wait_idle_a(100, v);
    cyc(5);
    n_checks++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL pend_extra_msg: busy=%b required 0", busy_a); end
    n_checks++;
    if (qa.size() !== 10) begin n_fail++; $display("FAIL pend_len: got %0d required 10", qa.size()); end
    for (int i = 0; i < 10; i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      n_checks++;
      if (got !== e[i]) begin n_fail++; $display("FAIL pend_byte%0d: got %h required %h", i, got, e[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e [10] = '{8'h39, 8'h39, 8'h39, 8'h0D, 8'h0A, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    logic [7:0] got;
    int v;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    pb_a = 1'b1;
    cyc(998);
    pb_a = 1'b0;
    wait_idle_a(200, v);
    n_checks++;
    if (count_a !== 12'h998) begin n_fail++; $display("FAIL wrap_preload: got %h required 998", count_a); end
    qa.delete();
    press_a();
    wait_idle_a(50, v);
    press_a();
    wait_idle_a(50, v);
    n_checks++;
    if (count_a !== 12'h000) begin n_fail++; $display("FAIL wrap_count: got %h required 000", count_a); end
    n_checks++;
    if (qa.size() !== 10) begin n_fail++; $display("FAIL wrap_len: got %0d required 10", qa.size()); end
    for (int i = 0; i < 10; i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      n_checks++;
      if (got !== e[i]) begin n_fail++; $display("FAIL wrap_byte%0d: got %h required %h", i, got, e[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e [3] = '{8'h30, 8'h30, 8'h31};
    logic [7:0] got;
    qa.delete();
    rdy_a = 1'b1;
    press_a();
    for (int i = 0; i < 20; i++) begin
      if (valid_a && data_a == 8'h0D) break;
      cyc(1);
    end
    n_checks++;
    if (valid_a !== 1'b1 || data_a !== 8'h0D) begin
      n_fail++; $display("FAIL rstmid_reach_cr: valid=%b data=%h required 1 0d", valid_a, data_a);
    end
    rst = 1'b1;
    cyc(1);
    n_checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || count_a !== 12'h000 || data_a !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_state: valid=%b busy=%b count=%h data=%h required 0 0 000 00",
               valid_a, busy_a, count_a, data_a);
    end
    rst = 1'b0;
    cyc(6);
    n_checks++;
    if (valid_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_lf: valid=%b required 0", valid_a); end
    n_checks++;
    if (qa.size() !== 3) begin n_fail++; $display("FAIL rstmid_len: got %0d required 3", qa.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      n_checks++;
      if (got !== e[i]) begin n_fail++; $display("FAIL rstmid_byte%0d: got %h required %h", i, got, e[i]); end
    end
  endtask

  task automatic test_single_digit_nocrlf();
    logic [7:0] got;
    logic [7:0] exp_b;
    qb.delete();
    rdy_b = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      pb_b = 1'b1;
      cyc(1);
      pb_b = 1'b0;
      wait_idle_b(20);
      cyc(2);
    end
    n_checks++;
    if (qb.size() !== 10) begin n_fail++; $display("FAIL b_len: got %0d required 10", qb.size()); end
    for (int i = 0; i < 10; i++) begin
      exp_b = 8'h30 + 8'((i + 1) % 10);
      got = (i < qb.size()) ? qb[i] : 8'hxx;
      n_checks++;
      if (got !== exp_b) begin n_fail++; $display("FAIL b_byte%0d: got %h required %h", i, got, exp_b); end
    end
    n_checks++;
    if (count_b !== 4'h0) begin n_fail++; $display("FAIL b_count: got %h required 0", count_b); end
  endtask

  initial begin
    rst   = 1'b1;
    pb_a  = 1'b0;
    pb_b  = 1'b0;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_pending();
    test_wrap();
    test_reset_mid();
    test_single_digit_nocrlf();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
